rr_arbiter_4ch: RTL
===================

# rr_arbiter_4ch

Four-channel round-robin arbiter that sits directly upstream of `decoder_2to4`. It samples four request lines and selects one channel fairly, then drives the decoder's select input `i` from `gnt_idx` and its `en` input from `gnt_en`, so the decoder's `y` becomes the one-hot grant bus. It holds the grant until the winner releases it or a hold timeout expires.

## Interface
- `MAX_HOLD`, default 15: maximum number of consecutive cycles `gnt_en` stays high for one grant. 0 disables the timeout. Legal range is 0–15.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req`  input  4  request lines; `req[k]` high means channel k wants the resource.
- `done`  input  1  release strobe from the current owner; only meaningful while `gnt_en` = 1.
- `gnt_idx`  output  2  index of the granted channel; connects to decoder `i`.
- `gnt_en`  output  1  grant valid; connects to decoder `en`.
- `timeout`  output  1  one-cycle pulse when a grant is revoked by the hold timer.

## Operation
- FSM has two states, IDLE and GRANT. All outputs are registered.
- Internal state:
  - `last` (2 bits): index of the most recent grant.
  - `hold_cnt` (4 bits): counts cycles within the current grant.
- Reset (`rst_n` = 0 at a rising edge) drives:
  - state = IDLE, `gnt_idx` = 2'b00, `gnt_en` = 0, `timeout` = 0.
  - `last` = 2'b11, so channel 0 has first priority.
  - `hold_cnt` = 0.
  - Reset overrides all other inputs, including mid-grant: `gnt_en` falls at the reset edge.
- IDLE:
  - If `req` = 0, stay in IDLE.
  - Otherwise pick the first asserted channel, scanning from (`last`+1) mod 4 upward with wrap-around 3→0.
  - Load `gnt_idx` with the winner, set `gnt_en` = 1, set `last` = winner, clear `hold_cnt`, and go to GRANT.
- GRANT, evaluated at each edge in this priority order:
  1. Release if `done` = 1 or `req[gnt_idx]` = 0. Set `gnt_en` = 0, `timeout` = 0, go to IDLE.
  2. Timeout if `MAX_HOLD` ≠ 0 and `hold_cnt` = `MAX_HOLD`−1. Set `gnt_en` = 0, `timeout` = 1, go to IDLE.
  3. Otherwise increment `hold_cnt` and stay in GRANT.
- `done` and timeout on the same edge: release wins and `timeout` stays 0.
- `gnt_idx` holds its last value while `gnt_en` = 0. The decoder's `y` is 0000 regardless.
- `done` is ignored in IDLE.
- `req` changes on channels other than the owner have no effect during GRANT.
- `timeout` is high for exactly one cycle, the first IDLE cycle after revocation.

## Timing
- Grant latency: `req` sampled high in IDLE at edge k gives `gnt_en` = 1 during the cycle after edge k, i.e. 1 cycle.
- Release: `done` sampled high at edge m gives `gnt_en` = 0 after edge m.
  - At least one IDLE cycle follows every grant.
  - The earliest next grant is visible after edge m+1.
- Maximum grant length is `MAX_HOLD` cycles of `gnt_en` = 1.
- Back-to-back service of four continuously requesting channels repeats with a period of 2 cycles per channel minimum (grant + idle gap).
- No combinational path from any input to any output.

## Test plan
- Reset, then `req` = 0000 for 5 cycles: `gnt_en` = 0, `gnt_idx` = 00, `timeout` = 0 throughout.
- `req` = 1111 held, `done` pulsed one cycle after each grant: `gnt_idx` sequence is 0,1,2,3,0. Each grant lasts 2 cycles high, separated by 1 idle cycle.
- `last` = 1 and `req` = 1001: winner is 3. Next arbitration with `req` = 1001 selects 0 (wrap-around).
- `MAX_HOLD` = 4, `req` = 0100 held, `done` = 0:
  - `gnt_idx` = 10 and `gnt_en` high for exactly 4 cycles, then `timeout` = 1 for 1 cycle.
  - Regrant of channel 2 occurs on the following cycle.
- `MAX_HOLD` = 4, `done` = 1 on the 4th grant cycle: release, with `timeout` = 0.
- Mid-grant owner `req` drop, then mid-grant `rst_n` = 0:
  - Owner `req` drop: `gnt_en` falls on the next edge.
  - `rst_n` = 0 mid-grant: `gnt_en` = 0 and `gnt_idx` = 00 after that edge.
  - After reset, `req` = 1111 grants channel 0 first.

Source files
------------

// File: rtl/rr_arbiter_4ch.sv
// Four-channel round-robin arbiter feeding a 2-to-4 decoder.
// One grant at a time: the owner keeps the resource until it pulses done,
// drops its request, or the optional hold timer expires. Every grant is
// followed by at least one IDLE cycle, so the next arbitration always sees
// fresh requests. All outputs come straight from flops.
module rr_arbiter_4ch #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] gnt_idx,
    output logic       gnt_en,
    output logic       timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // MAX_HOLD = 0 turns the hold timer off entirely.
    localparam bit         TIMEOUT_ON = (MAX_HOLD != 0);
    localparam logic [3:0] HOLD_LAST  = TIMEOUT_ON ? 4'(MAX_HOLD - 1) : 4'd0;

    state_t     state_r;
    logic [1:0] last_r;
    logic [3:0] hold_cnt_r;

    logic [2:0] pick_s;          // {found, winner index}
    logic       owner_req_s;
    logic       hold_expired_s;

    // Scan from the channel after the previous winner, wrapping 3 -> 0;
    // the first asserted request wins. Bit 2 flags that any request was found.
    function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [3:0] reqs);
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx    = last + 2'(k);
            result = (!result[2] && reqs[idx]) ? {1'b1, idx} : result;
        end
        return result;
    endfunction

    // Next-winner selection and the release/timeout conditions for the owner.
    always_comb begin
        pick_s         = rr_pick(last_r, req);
        owner_req_s    = req[gnt_idx];
        hold_expired_s = TIMEOUT_ON && (hold_cnt_r == HOLD_LAST);
    end

    // Arbiter FSM with registered grant outputs and hold counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            gnt_idx    <= 2'b00;
            gnt_en     <= 1'b0;
            timeout    <= 1'b0;
            last_r     <= 2'b11;
            hold_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    // timeout is only ever high for this first IDLE cycle
                    timeout <= 1'b0;
                    if (pick_s[2]) begin
                        gnt_idx    <= pick_s[1:0];
                        gnt_en     <= 1'b1;
                        last_r     <= pick_s[1:0];
                        hold_cnt_r <= 4'd0;
                        state_r    <= GRANT;
                    end else begin
                        gnt_en  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    // Release outranks the timer, so a coincident done never pulses timeout.
                    if (done || !owner_req_s) begin
                        gnt_en  <= 1'b0;
                        timeout <= 1'b0;
                        state_r <= IDLE;
                    end else if (hold_expired_s) begin
                        gnt_en  <= 1'b0;
                        timeout <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + 4'd1;
                        timeout    <= 1'b0;
                        state_r    <= GRANT;
                    end
                end
                default: begin
                    gnt_en  <= 1'b0;
                    timeout <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
